// File: rtl/gate_test_pkg.sv
// Shared types and constants for the COA lab gate checkers: FSM states,
// reference truth tables and the vector-count helper.
package gate_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } gate_state_e;

    // Bit i is the gate output for input value i.
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic int unsigned nvec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle down-counter: load arms it with SETTLE-1, expire_c fires on the
// enabled cycle where the count has reached zero.
module gate_settle_timer #(
    parameter int unsigned SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    assign expire_c = en && (count_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps every input combination onto a gate under test, samples its output
// after a settle time and checks the observed truth table against EXP_TT.
// Optional: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_sweep_checker
    import gate_test_pkg::*;
#(
    parameter int unsigned                N_IN   = 2,
    parameter int unsigned                SETTLE = 4,
    parameter logic [(2**N_IN)-1:0]       EXP_TT = TT_NAND
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   captured_tt,
    output logic [N_IN:0]          fail_count,
    output logic [N_IN-1:0]        fail_idx
);

    localparam int unsigned NVEC = nvec(N_IN);
    localparam int unsigned VW   = N_IN + 1;
    localparam logic [VW-1:0] LAST_VEC = VW'(NVEC - 1);

    gate_state_e     state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [NVEC-1:0] cap_q, cap_d;
    logic [VW-1:0]   fc_q, fc_d;
    logic [N_IN-1:0] fidx_q, fidx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic            tmr_load_c;
    logic            tmr_en_c;
    logic            tmr_expire_c;
    logic            mismatch_c;
    logic [N_IN-1:0] vidx_c;

    assign vidx_c     = vec_q[N_IN-1:0];
    assign mismatch_c = (dut_out != EXP_TT[vidx_c]);

    gate_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .en       (tmr_en_c),
        .expire_c (tmr_expire_c)
    );

    // Next-state and result datapath
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cap_d      = cap_q;
        fc_d       = fc_q;
        fidx_d     = fidx_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        tmr_load_c = 1'b0;
        tmr_en_c   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    vec_d      = '0;
                    cap_d      = '0;
                    fc_d       = '0;
                    fidx_d     = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    tmr_load_c = 1'b1;
                end
            end

            ST_SETTLE: begin
                tmr_en_c = 1'b1;
                if (tmr_expire_c) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                cap_d[vidx_c] = dut_out;
                if (mismatch_c) begin
                    fc_d = fc_q + VW'(1);
                    if (fc_q == '0) begin
                        fidx_d = vidx_c;
                    end
                end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                if (mismatch_c || (vec_q == LAST_VEC)) begin
`else
                if (vec_q == LAST_VEC) begin
`endif
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fc_d == '0);
                end else begin
                    state_d    = ST_SETTLE;
                    vec_d      = vec_q + VW'(1);
                    tmr_load_c = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cap_q   <= '0;
            fc_q    <= '0;
            fidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cap_q   <= cap_d;
            fc_q    <= fc_d;
            fidx_q  <= fidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_in      = vec_q[N_IN-1:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign captured_tt = cap_q;
    assign fail_count  = fc_q;
    assign fail_idx    = fidx_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker: table of gate behaviours,
// randomized truth tables against a reference model, and timing corner cases.
module tb_gate_sweep_checker;
    import gate_test_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy, done, pass;
    logic [3:0] captured_tt;
    logic [2:0] fail_count;
    logic [1:0] fail_idx;
    logic [3:0] dut_tt;

    logic       x_start;
    logic [1:0] x_dut_in;
    logic       x_dut_out;
    logic       x_busy, x_done, x_pass;
    logic [3:0] x_cap;
    logic [2:0] x_fc;
    logic [1:0] x_fidx;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign dut_out   = dut_tt[dut_in];
    assign x_dut_out = x_dut_in[0] ^ x_dut_in[1];

    gate_sweep_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .captured_tt(captured_tt),
        .fail_count(fail_count), .fail_idx(fail_idx)
    );

    gate_sweep_checker #(.N_IN(2), .SETTLE(1), .EXP_TT(TT_XOR)) u_xor (
        .clk(clk), .rst(rst), .start(x_start), .dut_in(x_dut_in), .dut_out(x_dut_out),
        .busy(x_busy), .done(x_done), .pass(x_pass), .captured_tt(x_cap),
        .fail_count(x_fc), .fail_idx(x_fidx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model derived directly from the sweep rules against NAND.
    task automatic ref_model(input logic [3:0] tt, output logic [3:0] cap, output int fc,
                             output int idx, output logic ps, output int lat);
        cap = 4'b0000; fc = 0; idx = 0; lat = 4 * 5;
        for (int i = 0; i < 4; i++) begin
            cap[i] = tt[i];
            if (tt[i] != TT_NAND[i]) begin
                if (fc == 0) idx = i;
                fc++;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                lat = (i + 1) * 5;
                break;
`endif
            end
        end
        ps = (fc == 0);
    endtask

    task automatic run_sweep(input logic [3:0] tt, input int pulse_at, output logic [3:0] cap,
                             output int fc, output int idx, output logic ps, output int lat);
        dut_tt = tt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 0;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        while (!done && lat < 200) begin
            if (lat == pulse_at) start = 1'b1;
            check("dut_in_step", dut_in, lat / 5);
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (!done) check("sweep_timeout", 0, 1);
        check("busy_in_done", busy, 0);
        cap = captured_tt; fc = fail_count; idx = fail_idx; ps = pass;
    endtask

    typedef struct {
        logic [3:0] tt;
        logic [3:0] cap;
        int         fc;
        int         idx;
        logic       ps;
        logic [3:0] cap_s;
        int         fc_s;
        int         lat_s;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [3:0] cap, e_cap;
        int fc, idx, lat, e_fc, e_idx, e_lat;
        logic ps, e_ps;

        tbl[0] = '{4'b0111, 4'b0111, 0, 0, 1'b1, 4'b0111, 0, 20};
        tbl[1] = '{4'b1111, 4'b1111, 1, 3, 1'b0, 4'b1111, 1, 20};
        tbl[2] = '{4'b1000, 4'b1000, 4, 0, 1'b0, 4'b0000, 1, 5};
        tbl[3] = '{4'b0000, 4'b0000, 3, 0, 1'b0, 4'b0000, 1, 5};
        tbl[4] = '{4'b0110, 4'b0110, 1, 0, 1'b0, 4'b0000, 1, 5};
        tbl[5] = '{4'b0101, 4'b0101, 1, 1, 1'b0, 4'b0001, 1, 10};

        rst = 1'b1; start = 1'b0; x_start = 1'b0; dut_tt = TT_NAND;
        repeat (3) @(negedge clk);
        check("rst_dut_in", dut_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_cap", captured_tt, 0);
        check("rst_fc", fail_count, 0);
        check("rst_fidx", fail_idx, 0);
        rst = 1'b0;

        for (int r = 0; r < 6; r++) begin
            run_sweep(tbl[r].tt, -1, cap, fc, idx, ps, lat);
            check("tbl_idx", idx, tbl[r].idx);
            check("tbl_pass", ps, tbl[r].ps);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
            check("tbl_cap", cap, tbl[r].cap_s);
            check("tbl_fc", fc, tbl[r].fc_s);
            check("tbl_lat", lat, tbl[r].lat_s);
`else
            check("tbl_cap", cap, tbl[r].cap);
            check("tbl_fc", fc, tbl[r].fc);
            check("tbl_lat", lat, 20);
`endif
        end

        // start during the sweep is ignored
        run_sweep(TT_NAND, 7, cap, fc, idx, ps, lat);
        check("ignore_start_lat", lat, 20);
        check("ignore_start_pass", ps, 1);
        repeat (3) @(negedge clk);
        check("done_held", done, 1);
        check("pass_held", pass, 1);

        // randomized truth tables, restarted from DONE
        for (int k = 0; k < 10; k++) begin
            logic [3:0] tt;
            tt = 4'($urandom);
            ref_model(tt, e_cap, e_fc, e_idx, e_ps, e_lat);
            run_sweep(tt, int'($urandom_range(1, 3)), cap, fc, idx, ps, lat);
            check("rnd_cap", cap, e_cap);
            check("rnd_fc", fc, e_fc);
            check("rnd_idx", idx, e_idx);
            check("rnd_pass", ps, e_ps);
            check("rnd_lat", lat, e_lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // reset mid-sweep aborts with no partial result
        dut_tt = TT_AND;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dut_in", dut_in, 0);
        check("midrst_cap", captured_tt, 0);
        check("midrst_fc", fail_count, 0);
        check("midrst_fidx", fail_idx, 0);
        @(negedge clk);
        check("midrst_stays_idle", busy, 0);
        run_sweep(TT_NAND, -1, cap, fc, idx, ps, lat);
        check("after_rst_lat", lat, 20);
        check("after_rst_pass", ps, 1);

        // rst wins over start
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        check("rst_wins_busy", busy, 0);
        check("rst_wins_done", done, 0);

        // SETTLE=1 with a correct XOR gate
        @(negedge clk) x_start = 1'b1;
        @(negedge clk) x_start = 1'b0;
        lat = 0;
        while (!x_done && lat < 100) begin
            check("xor_dut_in_step", x_dut_in, lat / 2);
            @(negedge clk);
            lat++;
        end
        check("xor_lat", lat, 8);
        check("xor_pass", x_pass, 1);
        check("xor_cap", x_cap, TT_XOR);
        check("xor_fc", x_fc, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
